// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU MEM stage
// and an auxiliary requester. CPU has priority, and a starvation counter forces
// an aux grant after MAX_WAIT denied cycles. aux_lock holds ownership for
// back-to-back aux accesses. Read data returns one cycle later, tagged to the
// port that was granted. Optional build macro: DMEM_ARB_STATS_EN, which adds
// saturating per-port grant and conflict counters.
//
// Ports:
//   clk, rst                            clock, async active-high reset
//   cpu_req/we/addr/wd                  CPU access request
//   cpu_stall                           CPU denied this cycle
//   cpu_rd, cpu_rvalid                  CPU read return
//   aux_req/we/addr/wd/lock             aux access request and lock
//   aux_gnt                             aux access accepted this cycle
//   aux_rd, aux_rvalid                  aux read return
//   mem_we/addr/wd, mem_rd              memory port (mem_rd is one-cycle latency)
//   stat_cpu_gnt/aux_gnt/conflict       only with DMEM_ARB_STATS_EN
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_rvalid,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wd,
    input  logic          aux_lock,
    output logic          aux_gnt,
    output logic [DW-1:0] aux_rd,
    output logic          aux_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_cpu_gnt,
    output logic [15:0]   stat_aux_gnt,
    output logic [15:0]   stat_conflict
`endif
);

    typedef enum logic {
        IDLE,
        AUX_LOCKED
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CPU,
        RD_AUX
    } rd_owner_t;

    state_t    state, state_nxt;
    rd_owner_t rd_owner, rd_owner_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;

    logic locked_aux;
    logic starve_max;
    logic cpu_grant;

    assign locked_aux = (state == AUX_LOCKED);
    assign starve_max = (starve_cnt == CW'(MAX_WAIT));

    always_comb begin
        aux_gnt      = 1'b0;
        cpu_grant    = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = cpu_addr;
        mem_wd       = cpu_wd;
        state_nxt    = state;
        starve_nxt   = starve_cnt;
        rd_owner_nxt = RD_NONE;

        aux_gnt   = aux_req & (locked_aux | starve_max | ~cpu_req);
        // A held lock blocks the CPU even in a cycle where aux is not asking.
        cpu_grant = cpu_req & ~aux_gnt & ~locked_aux;

        if (aux_gnt) begin
            mem_addr = aux_addr;
            mem_wd   = aux_wd;
            mem_we   = aux_we;
        end else if (cpu_grant) begin
            mem_we   = cpu_we;
        end

        unique case (state)
            IDLE:       if (aux_gnt & aux_lock) state_nxt = AUX_LOCKED;
            AUX_LOCKED: if (!aux_req || !aux_lock) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase

        if (!aux_req || aux_gnt) begin
            starve_nxt = '0;
        end else if (!starve_max) begin
            starve_nxt = starve_cnt + CW'(1);
        end

        if (aux_gnt && !aux_we) begin
            rd_owner_nxt = RD_AUX;
        end else if (cpu_grant && !cpu_we) begin
            rd_owner_nxt = RD_CPU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            rd_owner   <= RD_NONE;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            rd_owner   <= rd_owner_nxt;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_grant;
    assign cpu_rd     = mem_rd;
    assign aux_rd     = mem_rd;
    assign cpu_rvalid = (rd_owner == RD_CPU);
    assign aux_rvalid = (rd_owner == RD_AUX);

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cpu_gnt  <= '0;
            stat_aux_gnt  <= '0;
            stat_conflict <= '0;
        end else begin
            if (cpu_grant && !(&stat_cpu_gnt)) begin
                stat_cpu_gnt <= stat_cpu_gnt + 16'd1;
            end
            if (aux_gnt && !(&stat_aux_gnt)) begin
                stat_aux_gnt <= stat_aux_gnt + 16'd1;
            end
            if (cpu_req && aux_req && !(&stat_conflict)) begin
                stat_conflict <= stat_conflict + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random stimulus for dmem_arbiter, checked
// against a transaction-level reference model with its own memory image.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd, cpu_rd;
    logic          aux_req, aux_we, aux_lock, aux_gnt, aux_rvalid;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wd, aux_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wd(cpu_wd), .cpu_stall(cpu_stall), .cpu_rd(cpu_rd),
        .cpu_rvalid(cpu_rvalid),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wd(aux_wd), .aux_lock(aux_lock), .aux_gnt(aux_gnt),
        .aux_rd(aux_rd), .aux_rvalid(aux_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 16) return 32'hDEADBEEF;
        return 32'hA5000000 | (i * 32'h00010203);
    endfunction

    // Memory device: one-cycle read latency, loaded while rst is high.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (mem_we) begin
            ram[mem_addr[9:2]] <= mem_wd;
        end
        mem_rd <= ram[mem_addr[9:2]];
    end

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    bit          m_locked;
    int          m_wait;
    bit          e_cv, e_av;
    logic [31:0] e_rd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_wait   = 0;
        e_cv     = 0;
        e_av     = 0;
        e_rd     = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic idle_in();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wd = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wd = '0;
        aux_lock = 0;
    endtask

    // One clock cycle: entered at posedge+1, drives, checks, advances model.
    task automatic step(input bit creq, input bit cwe, input logic [31:0] ca,
                        input logic [31:0] cd, input bit areq, input bit awe,
                        input logic [31:0] aa, input logic [31:0] ad,
                        input bit alck);
        bit awin, cwin;
        cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wd = cd;
        aux_req = areq; aux_we = awe; aux_addr = aa; aux_wd = ad;
        aux_lock = alck;
        #1;
        awin = areq && (m_locked || m_wait == MW || !creq);
        cwin = creq && !awin && !m_locked;
        chk("aux_gnt", 32'(aux_gnt), 32'(awin));
        chk("cpu_stall", 32'(cpu_stall), 32'(creq && !cwin));
        chk("mem_we", 32'(mem_we), 32'(awin ? awe : (cwin ? cwe : 1'b0)));
        chk("mem_addr", mem_addr, awin ? aa : ca);
        chk("mem_wd", mem_wd, awin ? ad : cd);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cv));
        chk("aux_rvalid", 32'(aux_rvalid), 32'(e_av));
        if (e_cv) chk("cpu_rd", cpu_rd, e_rd);
        if (e_av) chk("aux_rd", aux_rd, e_rd);
        // Expected return for the next cycle, then apply writes.
        e_cv = cwin && !cwe;
        e_av = awin && !awe;
        e_rd = awin ? ref_mem[aa[9:2]] : ref_mem[ca[9:2]];
        if (awin && awe) ref_mem[aa[9:2]] = ad;
        if (cwin && cwe) ref_mem[ca[9:2]] = cd;
        if (areq && !awin) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        else m_wait = 0;
        if (m_locked) m_locked = areq && alck;
        else m_locked = awin && alck;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_chk();
        idle_in();
        rst = 1;
        #1;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_aux_gnt", 32'(aux_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    initial begin
        idle_in();
        rst = 1;
        model_reset();
        #2;
        reset_chk();

        // CPU alone read of 0x40, return next cycle.
        step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Aux alone write.
        step(0, 0, 0, 0, 1, 1, 32'h80, 32'h12345678, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Continuous contention: 4 CPU wins then aux, repeating.
        repeat (15) step(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Starve to the limit, then lock for 3 cycles, then release.
        repeat (4) step(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);
        repeat (3) step(1, 0, 32'h10, 0, 1, 1, 32'h24, 32'h55AA0000, 1);
        step(1, 0, 32'h24, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Alternating CPU / aux reads.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
            else step(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset the cycle after a granted CPU read.
        step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        reset_chk();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 rnd_addr(), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 rnd_addr(), $urandom, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
